float_pack: RTL and testbench

//  Inverse of the float field-decode path: packs sign / unnormalized significand / biased exponent into float_pkg::float_t.

---
 rtl/float_pkg.sv | 36 +++
 rtl/float_round_rne.sv | 44 ++++
 rtl/float_pack.sv | 238 +++++++++++++++++++++++
 tb/tb_float_pack.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// -----------------------------------------------------------------------------
// float_pkg
// Shared float format definitions (binary32 layout) used by the float datapath.
//   MantissaWidth / BiasedExponentWidth / ExponentBias : format constants
//   float_t              : packed {sign, exponent, mantissa}
//   float_pack_state_e   : sequencer states of float_pack
//   float_pack_flags_t   : {overflow, underflow, inexact} exception flags
// -----------------------------------------------------------------------------
package float_pkg;

    localparam int MantissaWidth       = 23;
    localparam int BiasedExponentWidth = 8;
    localparam int ExponentBias        = 127;

    typedef struct packed {
        logic                           sign;
        logic [BiasedExponentWidth-1:0] exponent;
        logic [MantissaWidth-1:0]       mantissa;
    } float_t;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DENORM,
        NORM,
        ROUND,
        OUT
    } float_pack_state_e;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } float_pack_flags_t;

endpackage

// File: rtl/float_round_rne.sv
// -----------------------------------------------------------------------------
// float_round_rne
// Combinational round-to-nearest-even of a significand carrying GuardBits
// extra LSBs (guard, round, ..., sticky) below the mantissa LSB.
// Ports:
//   sig_i      in  SW          significand, mantissa LSB at bit GuardBits
//   sig_o      out SW-GB-1     rounded significand without guard bits and
//                              without the carry position
//   carry_o    out 1           rounding overflowed into bit SW-1
//   inexact_o  out 1           any guard bit was set
// -----------------------------------------------------------------------------
module float_round_rne #(
    parameter int SW        = 28,
    parameter int GuardBits = 3
) (
    input  logic [SW-1:0]           sig_i,
    output logic [SW-GuardBits-2:0] sig_o,
    output logic                    carry_o,
    output logic                    inexact_o
);

    localparam int RW = SW - GuardBits;

    logic [RW-1:0] upper;
    logic [RW-1:0] sum;
    logic          lsb;
    logic          half;
    logic          rest;
    logic          round_up;

    always_comb begin
        upper     = sig_i[SW-1:GuardBits];
        lsb       = sig_i[GuardBits];
        half      = sig_i[GuardBits-1];
        rest      = |sig_i[GuardBits-2:0];
        inexact_o = half | rest;
        // exactly-half ties go to the even neighbour
        round_up  = half & (rest | lsb);
        sum       = upper + RW'(round_up);
        carry_o   = sum[RW-1];
        sig_o     = sum[RW-2:0];
    end

endmodule

// File: rtl/float_pack.sv
// -----------------------------------------------------------------------------
// float_pack
// Packs sign / unnormalized significand / signed biased exponent into a
// float_t. Normalizes one bit per cycle, rounds to nearest-even, produces
// subnormals, signed zero and infinity. One operation in flight.
// Optional feature macro: FLOAT_PACK_FLAGS_EN adds the flags_o port and the
// exception flag registers.
// Ports:
//   clk_i          in   clock
//   rst_i          in   asynchronous active-high reset
//   valid_i        in   operand valid
//   ready_o        out  idle, operand accepted when valid_i && ready_o
//   sign_i         in   sign
//   exponent_i     in   EW signed biased exponent of significand bit SW-2
//   significand_i  in   SW magnitude, binary point between bits SW-2/SW-3
//   valid_o        out  result valid, held until ready_i
//   ready_i        in   consumer accepts result
//   rdata_o        out  packed float result
//   flags_o        out  {overflow, underflow, inexact} (FLOAT_PACK_FLAGS_EN)
// -----------------------------------------------------------------------------
module float_pack
    import float_pkg::*;
#(
    parameter  int GuardBits = 3,
    localparam int SW        = MantissaWidth + 2 + GuardBits,
    localparam int EW        = BiasedExponentWidth + 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 sign_i,
    input  logic signed [EW-1:0] exponent_i,
    input  logic        [SW-1:0] significand_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output float_t               rdata_o
`ifdef FLOAT_PACK_FLAGS_EN
    ,
    output float_pack_flags_t    flags_o
`endif
);

    // One extra exponent bit so the pre-shift and round carry increments
    // cannot wrap for the largest input exponent.
    localparam int XW = EW + 1;

    localparam logic signed [EW-1:0] MinExpIn = EW'(1 - SW);
    localparam logic signed [XW-1:0] ExpOne   = XW'(1);
    localparam logic signed [XW-1:0] ExpInf   = XW'((1 << BiasedExponentWidth) - 1);

    float_pack_state_e state_q, state_d;

    logic                 sign_q, sign_d;
    logic        [SW-1:0] sig_q, sig_d;
    logic signed [XW-1:0] exp_q, exp_d;

    logic                 load_out;
    float_t               rdata_q, rdata_d;

    logic signed [EW-1:0]    exp_in;
    logic [MantissaWidth:0]  rnd_sig;
    logic                    rnd_carry;
    logic                    rnd_inexact;
    logic signed [XW-1:0]    exp_rnd;
    logic [MantissaWidth-1:0] mant_rnd;
    logic                    hidden_rnd;

`ifdef FLOAT_PACK_FLAGS_EN
    float_pack_flags_t flags_q, flags_d;
`endif

    // Right shift by one, folding the dropped bit into the sticky LSB.
    function automatic logic [SW-1:0] shr_sticky(input logic [SW-1:0] sig);
        return {1'b0, sig[SW-1:2], sig[1] | sig[0]};
    endfunction

    // Next phase after any shift step: denormalize while below the minimum
    // exponent, normalize left while hidden bit clear and exponent allows.
    function automatic float_pack_state_e pick_next(input logic hidden,
                                                    input logic signed [XW-1:0] exp);
        if (exp < ExpOne) begin
            return DENORM;
        end else if (!hidden && (exp > ExpOne)) begin
            return NORM;
        end else begin
            return ROUND;
        end
    endfunction

    float_round_rne #(
        .SW        (SW),
        .GuardBits (GuardBits)
    ) u_round (
        .sig_i     (sig_q),
        .sig_o     (rnd_sig),
        .carry_o   (rnd_carry),
        .inexact_o (rnd_inexact)
    );

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == OUT);
    assign rdata_o = rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        sig_d    = sig_q;
        exp_d    = exp_q;
        load_out = 1'b0;
        rdata_d  = '0;
`ifdef FLOAT_PACK_FLAGS_EN
        flags_d  = '0;
`endif

        // Exponents this small shift every bit into sticky anyway; clamping
        // bounds the DENORM loop.
        exp_in     = (exponent_i < MinExpIn) ? MinExpIn : exponent_i;

        // A round carry leaves only the carry bit set, so renormalizing is a
        // plain one-bit reselection of the mantissa.
        exp_rnd    = rnd_carry ? (exp_q + ExpOne) : exp_q;
        mant_rnd   = rnd_carry ? rnd_sig[MantissaWidth:1] : rnd_sig[MantissaWidth-1:0];
        hidden_rnd = rnd_carry | rnd_sig[MantissaWidth];

        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    sign_d  = sign_i;
                    sig_d   = significand_i;
                    exp_d   = {exp_in[EW-1], exp_in};
                    state_d = PRE;
                end
            end

            PRE: begin
                if (sig_q == '0) begin
                    rdata_d.sign = sign_q;
                    load_out     = 1'b1;
                    state_d      = OUT;
                end else begin
                    if (sig_q[SW-1]) begin
                        sig_d = shr_sticky(sig_q);
                        exp_d = exp_q + ExpOne;
                    end
                    state_d = pick_next(sig_d[SW-2], exp_d);
                end
            end

            DENORM: begin
                sig_d   = shr_sticky(sig_q);
                exp_d   = exp_q + ExpOne;
                state_d = pick_next(sig_d[SW-2], exp_d);
            end

            NORM: begin
                sig_d   = {sig_q[SW-2:0], 1'b0};
                exp_d   = exp_q - ExpOne;
                state_d = pick_next(sig_d[SW-2], exp_d);
            end

            ROUND: begin
                rdata_d.sign = sign_q;
                if (exp_rnd >= ExpInf) begin
                    rdata_d.exponent = '1;
                    rdata_d.mantissa = '0;
`ifdef FLOAT_PACK_FLAGS_EN
                    flags_d.overflow = 1'b1;
                    flags_d.inexact  = 1'b1;
`endif
                end else if (!hidden_rnd) begin
                    // Hidden bit still clear means exp is 1: subnormal or zero.
                    rdata_d.exponent = '0;
                    rdata_d.mantissa = mant_rnd;
`ifdef FLOAT_PACK_FLAGS_EN
                    flags_d.underflow = rnd_inexact;
                    flags_d.inexact   = rnd_inexact;
`endif
                end else begin
                    rdata_d.exponent = exp_rnd[BiasedExponentWidth-1:0];
                    rdata_d.mantissa = mant_rnd;
`ifdef FLOAT_PACK_FLAGS_EN
                    flags_d.inexact  = rnd_inexact;
`endif
                end
                load_out = 1'b1;
                state_d  = OUT;
            end

            OUT: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        sign_q <= sign_d;
        sig_q  <= sig_d;
        exp_q  <= exp_d;
    end

    // Result registers only load on entry to OUT, so they stay stable while
    // the consumer stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (load_out) begin
            rdata_q <= rdata_d;
        end
    end

`ifdef FLOAT_PACK_FLAGS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flags_q <= '0;
        end else if (load_out) begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;
`endif

endmodule

// File: tb/tb_float_pack.sv
module tb_float_pack;
    import float_pkg::*;

    localparam int SW = 28;
    localparam int EW = 10;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 valid_i;
    logic                 ready_o;
    logic                 sign_i;
    logic signed [EW-1:0] exponent_i;
    logic        [SW-1:0] significand_i;
    logic                 valid_o;
    logic                 ready_i;
    float_t               rdata_o;
`ifdef FLOAT_PACK_FLAGS_EN
    float_pack_flags_t    flags_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    float_pack #(.GuardBits(3)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .sign_i        (sign_i),
        .exponent_i    (exponent_i),
        .significand_i (significand_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .rdata_o       (rdata_o)
`ifdef FLOAT_PACK_FLAGS_EN
        ,
        .flags_o       (flags_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        s;
        int          e;
        logic [27:0] m;
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: exact value m * 2^(e-127-26), rounded to nearest-even onto
    // the binary32 grid (ulp fixed at 2^-149 below the normal range).
    function automatic void ref_pack(input logic s, input int e_in, input logic [27:0] m_in,
                                     output logic [31:0] res, output logic [2:0] fl,
                                     output int lat);
        int     e, p, be, d, ep, field;
        longint m, q, rem, half;
        bit     inx;
        e   = (e_in < -27) ? -27 : e_in;
        m   = longint'(m_in);
        res = {s, 31'd0};
        fl  = 3'b000;
        lat = 2;
        if (m == 0) return;
        p = 27;
        while (m[p] == 1'b0) p--;
        be  = e + p - 26;
        d   = (be < 1) ? (4 - e) : (p - 23);
        inx = 1'b0;
        if (d > 0) begin
            q    = m >> d;
            rem  = m & ((longint'(1) << d) - 1);
            half = longint'(1) << (d - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && q[0])) q++;
        end else begin
            q = m << (-d);
        end
        if (be < 1) begin
            field = (q >= (longint'(1) << 23)) ? 1 : 0;
        end else begin
            field = be;
            if (q >= (longint'(1) << 24)) begin
                q     = q >> 1;
                field = be + 1;
            end
        end
        if (field >= 255) begin
            res = {s, 8'hFF, 23'd0};
            fl  = 3'b101;
        end else begin
            res = {s, 8'(field), q[22:0]};
            fl  = {1'b0, (field == 0) && inx, inx};
        end
        // 3 cycles base, plus one per bit of denormalizing or normalizing
        ep = e + ((p == 27) ? 1 : 0);
        if (ep < 1) lat = 3 + (1 - ep);
        else if (p < 26) lat = 3 + (((26 - p) < (ep - 1)) ? (26 - p) : (ep - 1));
        else lat = 3;
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({name, " ready_o"}, 32'(ready_o), 32'd1);
    endtask

    task automatic run_op(input string name, input logic s, input int e, input logic [27:0] m,
                          input logic [31:0] xres, input logic [2:0] xfl, input int xlat);
        int n;
        wait_ready(name);
        sign_i        = s;
        exponent_i    = EW'(e);
        significand_i = m;
        valid_i       = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        n = 1;
        while (!valid_o && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({name, " valid_o"}, 32'(valid_o), 32'd1);
        check({name, " latency"}, 32'(n), 32'(xlat));
        check({name, " rdata"}, rdata_o, xres);
`ifdef FLOAT_PACK_FLAGS_EN
        check({name, " flags"}, 32'(flags_o), 32'(xfl));
`else
        if (xfl === 3'bxxx) $display("note: unexpected flag pattern");
`endif
        if (ready_i) begin
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        logic [31:0] xres;
        logic [2:0]  xfl;
        int          xlat;
        logic        s;
        int          e, w;
        logic [27:0] m;

        tbl[0] = '{"one",        1'b0, 127, 28'(1 << 26),           32'h3F800000, 3'b000, 3};
        tbl[1] = '{"norm3",      1'b0, 130, 28'(1 << 23),           32'h3F800000, 3'b000, 6};
        tbl[2] = '{"tie_even",   1'b0, 127, 28'((1 << 26) | 4),     32'h3F800000, 3'b001, 3};
        tbl[3] = '{"tie_odd",    1'b0, 127, 28'((1 << 26) | 12),    32'h3F800002, 3'b001, 3};
        tbl[4] = '{"inf",        1'b0, 255, 28'(1 << 26),           32'h7F800000, 3'b101, 3};
        tbl[5] = '{"subnormal",  1'b0, -1,  28'(1 << 26),           32'h00200000, 3'b000, 5};
        tbl[6] = '{"neg_zero",   1'b1, 5,   28'd0,                  32'h80000000, 3'b000, 2};
        tbl[7] = '{"carry_in",   1'b0, 127, 28'(1 << 27),           32'h40000000, 3'b000, 3};
        tbl[8] = '{"clamp",      1'b0, -300, 28'hFFFFFFF,           32'h00000000, 3'b011, 30};
        tbl[9] = '{"sub_to_min", 1'b1, 1,   28'((1 << 26) - 1),     32'h80800000, 3'b001, 3};

        rst_i         = 1'b1;
        valid_i       = 1'b0;
        ready_i       = 1'b1;
        sign_i        = 1'b0;
        exponent_i    = '0;
        significand_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset ready_o", 32'(ready_o), 32'd1);
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset rdata",   rdata_o,      32'd0);
`ifdef FLOAT_PACK_FLAGS_EN
        check("reset flags",   32'(flags_o), 32'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        foreach (tbl[i]) begin
            run_op(tbl[i].name, tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].res, tbl[i].fl, tbl[i].lat);
        end

        // Consumer stall: result and handshake must hold
        ready_i = 1'b0;
        run_op("stall", 1'b0, 127, 28'((1 << 26) | 12), 32'h3F800002, 3'b001, 3);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i); #1;
            check("stall valid_o", 32'(valid_o), 32'd1);
            check("stall rdata",   rdata_o,      32'h3F800002);
            check("stall ready_o", 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("release valid_o", 32'(valid_o), 32'd0);
        check("release ready_o", 32'(ready_o), 32'd1);

        // Reset in the middle of normalization
        sign_i        = 1'b0;
        exponent_i    = EW'(130);
        significand_i = 28'(1 << 23);
        valid_i       = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("midop valid_o", 32'(valid_o), 32'd0);
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("abort valid_o", 32'(valid_o), 32'd0);
        check("abort ready_o", 32'(ready_o), 32'd1);
        check("abort rdata",   rdata_o,      32'd0);
`ifdef FLOAT_PACK_FLAGS_EN
        check("abort flags",   32'(flags_o), 32'd0);
`endif
        run_op("after_abort", 1'b0, 130, 28'(1 << 23), 32'h3F800000, 3'b000, 6);

        // Randomized operands against the reference model
        for (int i = 0; i < 200; i++) begin
            s = 1'($urandom_range(0, 1));
            w = $urandom_range(0, 28);
            m = (w == 0) ? 28'd0 : 28'($urandom & ((32'd1 << w) - 32'd1));
            e = int'($urandom_range(0, 330)) - 45;
            ref_pack(s, e, m, xres, xfl, xlat);
            run_op("random", s, e, m, xres, xfl, xlat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
